// File: rtl/sample_uart_framer_if.sv
// UART transmit handshake between the sample framer (master) and the UART TX (slave).
`timescale 1ns/1ps

interface sample_uart_framer_if;
  logic       tx_ready;
  logic       tx_send;
  logic [7:0] tx_data;

  modport master (input tx_ready, output tx_send, output tx_data);
  modport slave  (output tx_ready, input tx_send, input tx_data);
endinterface

// File: rtl/sample_uart_framer.sv
// Buffers ADC samples in a FIFO and streams whole frames to the UART:
// SYNC, sequence number, big-endian sample bytes, then an 8-bit checksum.
`timescale 1ns/1ps

module sample_uart_framer #(
  parameter int          SAMPLE_W  = 12,
  parameter int          DEPTH     = 16,
  parameter int          FRAME_LEN = 8,
  parameter logic [7:0]  SYNC_BYTE = 8'hA5
) (
  input  logic                     clk,
  input  logic                     reset_b,
  input  logic [SAMPLE_W-1:0]      sample_in,
  input  logic                     sample_valid,
  input  logic                     data_logging,
  input  logic                     clear_ovf,
  sample_uart_framer_if.master     tx,
  output logic [$clog2(DEPTH):0]   fifo_count,
  output logic                     overflow,
  output logic                     busy
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int IDX_W = $clog2(FRAME_LEN + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SYNC,
    S_SEQ,
    S_HI,
    S_LO,
    S_CSUM
  } state_t;

  state_t            state;
  logic [7:0]        seq;
  logic [7:0]        checksum;
  logic              outstanding;
  logic              seen_low;
  logic [IDX_W-1:0]  sample_idx;

  logic [15:0]       mem [DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;

  logic              fire;
  logic              push;
  logic              pop;
  logic              drop;
  logic              full;
  logic [15:0]       head;
  logic [15:0]       sample_word;
  logic [7:0]        next_byte;

  // A byte goes out only when the UART is ready and the previous byte has
  // been seen to start (ready low) and finish (ready high again).
  assign fire = (state != S_IDLE) && tx.tx_ready && !outstanding;
  assign pop  = fire && (state == S_LO);
  assign full = (fifo_count == CNT_W'(DEPTH));
  assign push = sample_valid && data_logging && (!full || pop);
  assign drop = sample_valid && data_logging && full && !pop;
  assign head = mem[rd_ptr];

  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    sample_word = '0;
    sample_word[SAMPLE_W-1:0] = sample_in;
  end

  always_comb begin
    next_byte = '0;
    case (state)
      S_SYNC:  next_byte = SYNC_BYTE;
      S_SEQ:   next_byte = seq;
      S_HI:    next_byte = head[15:8];
      S_LO:    next_byte = head[7:0];
      S_CSUM:  next_byte = checksum;
      default: next_byte = '0;
    endcase
  end

  // NOTE: sample storage has no reset; only pointers and count define its contents.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= sample_word;
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk or posedge reset_b) begin
    if (reset_b) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
      overflow   <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   fifo_count <= fifo_count + CNT_W'(1);
        2'b01:   fifo_count <= fifo_count - CNT_W'(1);
        default: fifo_count <= fifo_count;
      endcase
      // A drop in the same cycle as a clear leaves the flag set.
      if (drop)           overflow <= 1'b1;
      else if (clear_ovf) overflow <= 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset_b) begin
    if (reset_b) begin
      state       <= S_IDLE;
      seq         <= '0;
      checksum    <= '0;
      outstanding <= 1'b0;
      seen_low    <= 1'b0;
      sample_idx  <= '0;
      busy        <= 1'b0;
      tx.tx_send  <= 1'b0;
      tx.tx_data  <= '0;
    end else begin
      tx.tx_send <= 1'b0;

      if (outstanding) begin
        if (!tx.tx_ready) begin
          seen_low <= 1'b1;
        end else if (seen_low) begin
          outstanding <= 1'b0;
          seen_low    <= 1'b0;
        end
      end

      if (fire) begin
        tx.tx_send  <= 1'b1;
        tx.tx_data  <= next_byte;
        outstanding <= 1'b1;
        seen_low    <= 1'b0;
      end

      case (state)
        S_IDLE: begin
          // Frames start on queue depth alone, so queued data drains even after logging stops.
          if (fifo_count >= CNT_W'(FRAME_LEN)) begin
            state    <= S_SYNC;
            busy     <= 1'b1;
            checksum <= '0;
          end
        end
        S_SYNC: begin
          if (fire) state <= S_SEQ;
        end
        S_SEQ: begin
          if (fire) begin
            checksum <= checksum + seq;
            state    <= S_HI;
          end
        end
        S_HI: begin
          if (fire) begin
            checksum <= checksum + head[15:8];
            state    <= S_LO;
          end
        end
        S_LO: begin
          if (fire) begin
            checksum <= checksum + head[7:0];
            if (sample_idx == IDX_W'(FRAME_LEN - 1)) begin
              sample_idx <= '0;
              state      <= S_CSUM;
            end else begin
              sample_idx <= sample_idx + IDX_W'(1);
              state      <= S_HI;
            end
          end
        end
        S_CSUM: begin
          if (fire) begin
            seq   <= seq + 8'd1;
            busy  <= 1'b0;
            state <= S_IDLE;
          end
        end
        default: begin
          state <= S_IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sample_uart_framer.sv
// Scoreboard bench for sample_uart_framer: directed sample patterns, expected bytes queued, monitor compares.
`timescale 1ns/1ps

module tb_sample_uart_framer;
  localparam int SAMPLE_W  = 12;
  localparam int DEPTH     = 16;
  localparam int FRAME_LEN = 8;

  logic                clk = 1'b0;
  logic                reset_b;
  logic [SAMPLE_W-1:0] sample_in;
  logic                sample_valid;
  logic                data_logging;
  logic                clear_ovf;
  logic [4:0]          fifo_count;
  logic                overflow;
  logic                busy;

  sample_uart_framer_if tx_if ();

  logic uart_manual, man_ready, auto_ready, uart_hold, uart_stuck;
  int   uart_delay;
  int   uart_cnt;

  assign tx_if.tx_ready = uart_manual ? man_ready : auto_ready;

  sample_uart_framer #(
    .SAMPLE_W (SAMPLE_W),
    .DEPTH    (DEPTH),
    .FRAME_LEN(FRAME_LEN),
    .SYNC_BYTE(8'hA5)
  ) dut (
    .clk         (clk),
    .reset_b     (reset_b),
    .sample_in   (sample_in),
    .sample_valid(sample_valid),
    .data_logging(data_logging),
    .clear_ovf   (clear_ovf),
    .tx          (tx_if),
    .fifo_count  (fifo_count),
    .overflow    (overflow),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  int          tests_run = 0;
  int          fails = 0;
  logic [7:0]  exp_q[$];
  logic [15:0] mq[$];
  logic [7:0]  exp_seq;
  logic [7:0]  exp_b;
  logic [7:0]  last_byte;

  task automatic check(input string name, input int actual, input int expected);
    tests_run++;
    if (actual !== expected) begin
      fails++;
      $display("FAIL %s: got %0h, required %0h", name, actual, expected);
    end
  endtask

  // Monitor: every pulse on tx_send is matched against the scoreboard queue.
  initial begin
    forever begin
      @(negedge clk);
      if (tx_if.tx_send === 1'b1) begin
        last_byte = tx_if.tx_data;
        if (exp_q.size() == 0) begin
          tests_run++;
          fails++;
          $display("FAIL tx_unexpected: got byte %02h, required no byte", tx_if.tx_data);
        end else begin
          exp_b = exp_q.pop_front();
          check("tx_byte", tx_if.tx_data, exp_b);
        end
      end
    end
  end

  // UART model: ready drops right after each pulse and returns uart_delay cycles later.
  initial begin
    auto_ready = 1'b1;
    uart_cnt   = 0;
    forever begin
      @(negedge clk);
      if (uart_hold) begin
        auto_ready = 1'b0;
      end else if (tx_if.tx_send === 1'b1 && !uart_stuck) begin
        auto_ready = 1'b0;
        uart_cnt   = uart_delay;
      end else if (uart_cnt > 0) begin
        uart_cnt--;
        auto_ready = (uart_cnt == 0);
      end else begin
        auto_ready = 1'b1;
      end
    end
  end

  task automatic drive_sample(input logic [SAMPLE_W-1:0] v);
    @(negedge clk);
    sample_in    = v;
    sample_valid = 1'b1;
    @(negedge clk);
    sample_valid = 1'b0;
  endtask

  task automatic model_push(input logic [SAMPLE_W-1:0] v);
    mq.push_back({4'h0, v});
  endtask

  // Builds one frame from the model FIFO and queues its first nbytes bytes.
  task automatic queue_frame(input int nbytes);
    logic [7:0]  b[$];
    logic [7:0]  cs;
    logic [15:0] s;
    b.push_back(8'hA5);
    b.push_back(exp_seq);
    cs = exp_seq;
    for (int i = 0; i < FRAME_LEN; i++) begin
      s = mq.pop_front();
      b.push_back(s[15:8]);
      b.push_back(s[7:0]);
      cs = cs + s[15:8] + s[7:0];
    end
    b.push_back(cs);
    exp_seq = exp_seq + 8'd1;
    for (int i = 0; i < nbytes && i < b.size(); i++) exp_q.push_back(b[i]);
  endtask

  task automatic wait_drain(input string name, input int budget);
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (exp_q.size() == 0 && !busy) break;
    end
    check({name, "_drained"}, exp_q.size(), 0);
    check({name, "_idle"}, busy, 0);
  endtask

  task automatic wait_pulses(input string name, input int n, input int budget);
    int seen;
    seen = 0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (tx_if.tx_send === 1'b1) seen++;
      if (seen == n) break;
    end
    check(name, seen, n);
  endtask

  task automatic send_byte_manual();
    int seen;
    seen = 0;
    man_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (tx_if.tx_send === 1'b1) begin
        seen = 1;
        break;
      end
    end
    check("man_pulse", seen, 1);
    man_ready = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    int extra;
    reset_b      = 1'b1;
    sample_in    = '0;
    sample_valid = 1'b0;
    data_logging = 1'b1;
    clear_ovf    = 1'b0;
    uart_manual  = 1'b0;
    man_ready    = 1'b0;
    uart_hold    = 1'b0;
    uart_stuck   = 1'b0;
    uart_delay   = 100;
    exp_seq      = 8'h00;
    repeat (3) @(negedge clk);
    reset_b = 1'b0;
    @(negedge clk);
    check("rst_tx_send", tx_if.tx_send, 0);
    check("rst_tx_data", tx_if.tx_data, 0);
    check("rst_count", fifo_count, 0);
    check("rst_overflow", overflow, 0);
    check("rst_busy", busy, 0);

    // Ramp 0x001..0x008 with a slow UART: A5 00 00 01 ... 00 08 24.
    for (int i = 1; i <= 8; i++) begin
      drive_sample(SAMPLE_W'(i));
      model_push(SAMPLE_W'(i));
      if (i == 7) begin
        check("ramp_no_early_tx", busy, 0);
        check("ramp_count7", fifo_count, 7);
      end
    end
    queue_frame(19);
    wait_drain("ramp", 3000);
    check("ramp_csum", last_byte, 8'h24);
    check("ramp_count", fifo_count, 0);

    // Overflow: 20 strobes with the UART stalled.
    uart_delay = 4;
    uart_hold  = 1'b1;
    for (int i = 0; i < 20; i++) begin
      drive_sample(SAMPLE_W'(12'h100 + i));
      if (i < 16) model_push(SAMPLE_W'(12'h100 + i));
    end
    check("ovf_count", fifo_count, 16);
    check("ovf_flag", overflow, 1);
    @(negedge clk); clear_ovf = 1'b1;
    @(negedge clk); clear_ovf = 1'b0;
    check("ovf_cleared", overflow, 0);
    @(negedge clk); clear_ovf = 1'b1; sample_in = 12'hFFF; sample_valid = 1'b1;
    @(negedge clk); clear_ovf = 1'b0; sample_valid = 1'b0;
    check("ovf_set_wins", overflow, 1);
    check("ovf_count_hold", fifo_count, 16);
    @(negedge clk); clear_ovf = 1'b1;
    @(negedge clk); clear_ovf = 1'b0;
    queue_frame(19);
    queue_frame(19);
    uart_hold = 1'b0;
    wait_drain("ovf", 1500);
    check("ovf_count_end", fifo_count, 0);
    check("ovf_flag_end", overflow, 0);

    // Push coinciding with a LO pop while full.
    uart_manual = 1'b1;
    man_ready   = 1'b0;
    for (int i = 0; i < 16; i++) begin
      drive_sample(SAMPLE_W'(12'h500 + i));
      model_push(SAMPLE_W'(12'h500 + i));
    end
    queue_frame(19);
    queue_frame(19);
    repeat (3) send_byte_manual();
    man_ready = 1'b1;
    @(negedge clk);
    check("pp_no_early_lo", tx_if.tx_send, 0);
    sample_in    = 12'h5AB;
    sample_valid = 1'b1;
    @(negedge clk);
    sample_valid = 1'b0;
    check("pp_lo_pulse", tx_if.tx_send, 1);
    check("pp_count", fifo_count, 16);
    check("pp_overflow", overflow, 0);
    model_push(12'h5AB);
    man_ready = 1'b0;
    @(negedge clk);
    uart_manual = 1'b0;
    wait_drain("pp", 1000);
    check("pp_leftover", fifo_count, 1);

    // Logging drops after the 3rd byte: the frame completes, later strobes are ignored.
    for (int i = 0; i < 7; i++) begin
      drive_sample(SAMPLE_W'(12'h600 + i));
      model_push(SAMPLE_W'(12'h600 + i));
    end
    queue_frame(19);
    wait_pulses("logoff_3bytes", 3, 200);
    data_logging = 1'b0;
    for (int i = 0; i < 4; i++) drive_sample(SAMPLE_W'(12'h7F0 + i));
    wait_drain("logoff", 500);
    check("logoff_count", fifo_count, 0);
    drive_sample(12'h7FF);
    check("logoff_ignored", fifo_count, 0);
    data_logging = 1'b1;

    // Reset during HI of sample 4 (11th byte).
    for (int i = 0; i < 8; i++) begin
      drive_sample(SAMPLE_W'(12'h3C0 + i));
      model_push(SAMPLE_W'(12'h3C0 + i));
    end
    queue_frame(11);
    wait_pulses("rst_mid_11bytes", 11, 400);
    #1 reset_b = 1'b1;
    #1;
    check("rst_mid_tx_send", tx_if.tx_send, 0);
    check("rst_mid_busy", busy, 0);
    check("rst_mid_count", fifo_count, 0);
    mq.delete();
    exp_seq = 8'h00;
    repeat (2) @(negedge clk);
    reset_b = 1'b0;
    for (int i = 0; i < 8; i++) begin
      drive_sample(SAMPLE_W'(12'h0E0 + i));
      model_push(SAMPLE_W'(12'h0E0 + i));
    end
    queue_frame(19);
    wait_drain("post_rst", 500);

    // Handshake violation: ready stays high after the pulse, so only SYNC goes out.
    repeat (20) @(negedge clk);
    uart_stuck = 1'b1;
    for (int i = 0; i < 8; i++) drive_sample(SAMPLE_W'(12'h011 + i));
    exp_q.push_back(8'hA5);
    wait_pulses("stuck_first", 1, 50);
    extra = 0;
    repeat (60) begin
      @(negedge clk);
      if (tx_if.tx_send === 1'b1) extra++;
    end
    check("stuck_extra", extra, 0);
    check("stuck_busy", busy, 1);
    #1 reset_b = 1'b1;
    repeat (2) @(negedge clk);
    reset_b = 1'b0;
    uart_stuck = 1'b0;
    repeat (2) @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", tests_run, fails);
    $finish;
  end

endmodule
